dcache_port_arbiter: RTL and testbench

- Sequences the single data-cache access port and shares it between two requesters.
- Port 0 is the stage-1 pipeline controller (load/store via MAR/MDR). Port 1 is the input-device block-transfer engine.
- Latches the winning request, holds the cache enable/rw/address/data stable until the cache signals completion, returns read data and a one-cycle done pulse to the winner.
- Guards against a hung cache with a timeout counter.

---
 rtl/dcache_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_dcache_port_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_port_arbiter.sv
// rtl/dcache_port_arbiter.sv - two-port arbiter/sequencer for the single data-cache access port
// Optional round-robin arbitration is enabled by defining DCACHE_ARB_RR_EN.
module dcache_port_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          g_clk,
    input  logic          g_clr,
    input  logic          req0,
    input  logic          rw0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          done0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          rw1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          done1,
    output logic [DW-1:0] rdata1,
    output logic          ch_en,
    output logic          ch_rw,
    output logic [AW-1:0] ch_addr,
    output logic [DW-1:0] ch_wdata,
    input  logic          ch_done,
    input  logic [DW-1:0] ch_rdata,
    output logic          busy,
    output logic          owner,
    output logic          timeout_err
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    cnt;
    logic [7:0]    cnt_nxt;
    logic [7:0]    cnt_inc;
    logic          any_req;
    logic          win;
    logic          tmo;

    logic          gnt0_nxt;
    logic          gnt1_nxt;
    logic          done0_nxt;
    logic          done1_nxt;
    logic [DW-1:0] rdata0_nxt;
    logic [DW-1:0] rdata1_nxt;
    logic          ch_en_nxt;
    logic          ch_rw_nxt;
    logic [AW-1:0] ch_addr_nxt;
    logic [DW-1:0] ch_wdata_nxt;
    logic          busy_nxt;
    logic          owner_nxt;
    logic          terr_nxt;

    assign any_req = req0 | req1;
    assign cnt_inc = cnt + 8'd1;
    // ch_done on the expiry edge wins, so the abort only fires without it
    assign tmo     = (state == BUSY) && !ch_done && (cnt_inc == TMO);

`ifdef DCACHE_ARB_RR_EN
    logic last;

    assign win = (req0 && req1) ? ~last : req1;

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            last <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last <= win;
        end
    end
`else
    assign win = ~req0 & req1;
`endif

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BUSY;
            BUSY:    if (ch_done || tmo) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt0_nxt     = 1'b0;
        gnt1_nxt     = 1'b0;
        done0_nxt    = 1'b0;
        done1_nxt    = 1'b0;
        rdata0_nxt   = rdata0;
        rdata1_nxt   = rdata1;
        ch_en_nxt    = ch_en;
        ch_rw_nxt    = ch_rw;
        ch_addr_nxt  = ch_addr;
        ch_wdata_nxt = ch_wdata;
        owner_nxt    = owner;
        terr_nxt     = timeout_err;
        cnt_nxt      = cnt;
        busy_nxt     = (state_nxt != IDLE);
        case (state)
            IDLE: begin
                if (any_req) begin
                    ch_en_nxt    = 1'b1;
                    ch_rw_nxt    = win ? rw1 : rw0;
                    ch_addr_nxt  = win ? addr1 : addr0;
                    ch_wdata_nxt = win ? wdata1 : wdata0;
                    owner_nxt    = win;
                    gnt0_nxt     = ~win;
                    gnt1_nxt     = win;
                    cnt_nxt      = 8'd0;
                end
            end
            BUSY: begin
                cnt_nxt = cnt_inc;
                if (ch_done) begin
                    ch_en_nxt = 1'b0;
                    done0_nxt = ~owner;
                    done1_nxt = owner;
                    if (ch_rw && !owner) rdata0_nxt = ch_rdata;
                    if (ch_rw && owner)  rdata1_nxt = ch_rdata;
                end else if (tmo) begin
                    ch_en_nxt = 1'b0;
                    terr_nxt  = 1'b1;
                    done0_nxt = ~owner;
                    done1_nxt = owner;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
            ch_en       <= 1'b0;
            ch_rw       <= 1'b0;
            ch_addr     <= '0;
            ch_wdata    <= '0;
            busy        <= 1'b0;
            owner       <= 1'b0;
            timeout_err <= 1'b0;
            cnt         <= 8'd0;
        end else begin
            gnt0        <= gnt0_nxt;
            gnt1        <= gnt1_nxt;
            done0       <= done0_nxt;
            done1       <= done1_nxt;
            rdata0      <= rdata0_nxt;
            rdata1      <= rdata1_nxt;
            ch_en       <= ch_en_nxt;
            ch_rw       <= ch_rw_nxt;
            ch_addr     <= ch_addr_nxt;
            ch_wdata    <= ch_wdata_nxt;
            busy        <= busy_nxt;
            owner       <= owner_nxt;
            timeout_err <= terr_nxt;
            cnt         <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb/tb_dcache_port_arbiter.sv - self-checking bench for dcache_port_arbiter
module tb_dcache_port_arbiter;

    localparam int TMO = 15;

    logic       g_clk = 1'b0;
    logic       g_clr = 1'b0;
    logic       req0 = 0, rw0 = 0, req1 = 0, rw1 = 0;
    logic [7:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
    logic       gnt0, done0, gnt1, done1;
    logic [7:0] rdata0, rdata1;
    logic       ch_en, ch_rw, ch_done = 0;
    logic [7:0] ch_addr, ch_wdata, ch_rdata = 0;
    logic       busy, owner, timeout_err;

    int errors = 0;
    int checks = 0;
    logic       last_m = 1'b1;
    logic       p_rw [2];
    logic [7:0] p_addr [2];
    logic [7:0] p_wdata [2];

    typedef struct {
        int         port;
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         lat;
        logic [7:0] crd;
        logic [7:0] e_rd0;
        logic [7:0] e_rd1;
        logic       e_terr;
        int         e_en;
    } vec_t;

    vec_t tbl [7];

    dcache_port_arbiter #(.AW(8), .DW(8), .TIMEOUT(TMO)) dut (
        .g_clk(g_clk), .g_clr(g_clr),
        .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .done0(done0), .rdata0(rdata0),
        .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .done1(done1), .rdata1(rdata1),
        .ch_en(ch_en), .ch_rw(ch_rw), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_done(ch_done), .ch_rdata(ch_rdata),
        .busy(busy), .owner(owner), .timeout_err(timeout_err)
    );

    always #5 g_clk = ~g_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int p, input logic r);
        if (p == 0) begin
            req0 = r; rw0 = p_rw[0]; addr0 = p_addr[0]; wdata0 = p_wdata[0];
        end else begin
            req1 = r; rw1 = p_rw[1]; addr1 = p_addr[1]; wdata1 = p_wdata[1];
        end
    endtask

    function automatic int pick(input bit r0, input bit r1);
`ifdef DCACHE_ARB_RR_EN
        if (r0 && r1) return last_m ? 0 : 1;
`endif
        return r0 ? 0 : 1;
    endfunction

    // Waits for the grant, then plays the cache for one transaction while
    // scrambling the winner's inputs; returns the number of ch_en cycles.
    task automatic exec_txn(input int w, input logic rw, input logic [7:0] a,
                            input logic [7:0] d, input int lat, input logic [7:0] crd,
                            output int en_cnt);
        bit hold_bad;
        for (int n = 0; n < 6; n++) begin
            @(posedge g_clk); #1;
            if (gnt0 || gnt1) break;
        end
        chk("gnt0", gnt0, w == 0);
        chk("gnt1", gnt1, w == 1);
        chk("grant_ch_en", ch_en, 1);
        chk("grant_ch_rw", ch_rw, rw);
        chk("grant_ch_addr", ch_addr, a);
        chk("grant_ch_wdata", ch_wdata, d);
        chk("grant_owner", owner, w);
        chk("grant_busy", busy, 1);
        last_m = (w == 1);
        en_cnt = 0;
        hold_bad = 0;
        for (int k = 1; k <= TMO + 3 && ch_en; k++) begin
            en_cnt++;
            if (ch_addr !== a || ch_wdata !== d || ch_rw !== rw || busy !== 1'b1) hold_bad = 1;
            if (k > 1 && (gnt0 || gnt1)) hold_bad = 1;
            if (done0 || done1) hold_bad = 1;
            ch_done  = (k == lat);
            ch_rdata = (k == lat) ? crd : 8'($urandom);
            if (w == 0) begin addr0 = 8'($urandom); wdata0 = 8'($urandom); end
            else        begin addr1 = 8'($urandom); wdata1 = 8'($urandom); end
            @(posedge g_clk); #1;
            ch_done = 0;
        end
        chk("busy_hold", hold_bad, 0);
        chk("done0", done0, w == 0);
        chk("done1", done1, w == 1);
        chk("done_ch_en", ch_en, 0);
    endtask

    // Requester drops its req in the cycle after done.
    task automatic release_port(input int w);
        @(posedge g_clk); #1;
        if (w == 0) req0 = 0; else req1 = 0;
        chk("idle_done", done0 | done1, 0);
        chk("idle_busy", busy, 0);
    endtask

    task automatic do_reset();
        g_clr = 0;
        #3;
        last_m = 1'b1;
        @(negedge g_clk);
        g_clr = 1;
    endtask

    initial begin
        int en, w;
        logic [7:0] rd_m [2];
        logic terr_m;
        bit pend [2];
        int lat;
        logic [7:0] crd;

        tbl[0] = '{0, 1'b1, 8'h03, 8'h00, 3,  8'h5A, 8'h5A, 8'h00, 1'b0, 3};
        tbl[1] = '{1, 1'b0, 8'h07, 8'h22, 1,  8'h99, 8'h5A, 8'h00, 1'b0, 1};
        tbl[2] = '{1, 1'b1, 8'h10, 8'h00, 2,  8'hC3, 8'h5A, 8'hC3, 1'b0, 2};
        tbl[3] = '{0, 1'b0, 8'h20, 8'h11, 1,  8'h66, 8'h5A, 8'hC3, 1'b0, 1};
        tbl[4] = '{1, 1'b1, 8'h40, 8'h00, 15, 8'h0E, 8'h5A, 8'h0E, 1'b0, 15};
        tbl[5] = '{0, 1'b1, 8'h30, 8'h00, 20, 8'h77, 8'h5A, 8'h0E, 1'b1, 15};
        tbl[6] = '{1, 1'b1, 8'h41, 8'h00, 1,  8'h44, 8'h5A, 8'h44, 1'b1, 1};

        #12;
        chk("rst_ch_en", ch_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", {gnt0, gnt1}, 0);
        chk("rst_done", {done0, done1}, 0);
        chk("rst_rdata", {rdata0, rdata1}, 0);
        chk("rst_misc", {owner, timeout_err, ch_rw, ch_addr, ch_wdata}, 0);
        @(negedge g_clk);
        g_clr = 1;

        for (int i = 0; i < 7; i++) begin
            p_rw[tbl[i].port]    = tbl[i].rw;
            p_addr[tbl[i].port]  = tbl[i].addr;
            p_wdata[tbl[i].port] = tbl[i].wdata;
            drive(tbl[i].port, 1'b1);
            exec_txn(tbl[i].port, tbl[i].rw, tbl[i].addr, tbl[i].wdata,
                     tbl[i].lat, tbl[i].crd, en);
            chk("tbl_en_cycles", en, tbl[i].e_en);
            chk("tbl_rdata0", rdata0, tbl[i].e_rd0);
            chk("tbl_rdata1", rdata1, tbl[i].e_rd1);
            chk("tbl_timeout_err", timeout_err, tbl[i].e_terr);
            release_port(tbl[i].port);
        end

        // Simultaneous requests, each released after its own done, twice.
        for (int rep = 0; rep < 2; rep++) begin
            p_rw[0] = 1; p_addr[0] = 8'h50 + 8'(rep); p_wdata[0] = 8'h00;
            p_rw[1] = 1; p_addr[1] = 8'h60 + 8'(rep); p_wdata[1] = 8'h00;
            drive(0, 1'b1);
            drive(1, 1'b1);
            w = pick(1, 1);
            exec_txn(w, 1'b1, p_addr[w], 8'h00, 1, 8'hA0 + 8'(w), en);
            release_port(w);
            exec_txn(1 - w, 1'b1, p_addr[1 - w], 8'h00, 2, 8'hB0, en);
            chk("pair_second_rdata", (w == 0) ? rdata1 : rdata0, 8'hB0);
            release_port(1 - w);
        end

        // Asynchronous reset in the middle of BUSY, request still pending.
        p_rw[0] = 1; p_addr[0] = 8'h0C; p_wdata[0] = 8'h00;
        drive(0, 1'b1);
        for (int n = 0; n < 6; n++) begin
            @(posedge g_clk); #1;
            if (gnt0) break;
        end
        chk("mid_gnt0", gnt0, 1);
        @(posedge g_clk); #3;
        g_clr = 0;
        #1;
        chk("async_ch_en", ch_en, 0);
        chk("async_busy", busy, 0);
        chk("async_gnt_done", {gnt0, gnt1, done0, done1}, 0);
        chk("async_terr", timeout_err, 0);
        last_m = 1'b1;
        @(negedge g_clk);
        g_clr = 1;
        exec_txn(0, 1'b1, 8'h0C, 8'h00, 2, 8'h3C, en);
        chk("post_rst_rdata0", rdata0, 8'h3C);
        chk("post_rst_rdata1", rdata1, 8'h00);
        release_port(0);

        // Randomized traffic against a transaction-level model.
        do_reset();
        rd_m[0] = 0; rd_m[1] = 0; terr_m = 0;
        pend[0] = 0; pend[1] = 0;
        for (int it = 0; it < 40; it++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 1) == 1) begin
                    pend[p]    = 1;
                    p_rw[p]    = 1'($urandom_range(0, 1));
                    p_addr[p]  = 8'($urandom);
                    p_wdata[p] = 8'($urandom);
                    drive(p, 1'b1);
                end
            end
            if (!pend[0] && !pend[1]) begin
                w = $urandom_range(0, 1);
                pend[w] = 1;
                p_rw[w] = 1'($urandom_range(0, 1));
                p_addr[w] = 8'($urandom);
                p_wdata[w] = 8'($urandom);
                drive(w, 1'b1);
            end
            w   = pick(pend[0], pend[1]);
            lat = $urandom_range(1, TMO + 3);
            crd = 8'($urandom);
            exec_txn(w, p_rw[w], p_addr[w], p_wdata[w], lat, crd, en);
            if (lat <= TMO && p_rw[w]) rd_m[w] = crd;
            if (lat > TMO) terr_m = 1;
            chk("rnd_en_cycles", en, (lat < TMO) ? lat : TMO);
            chk("rnd_rdata0", rdata0, rd_m[0]);
            chk("rnd_rdata1", rdata1, rd_m[1]);
            chk("rnd_timeout_err", timeout_err, terr_m);
            pend[w] = 0;
            release_port(w);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
